// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with a small byte-addressed instruction memory.
// Each accepted cycle presents one 32-bit little-endian word read at the
// internal pc through a registered ready/valid output stage.
//
// Redirects load a new pc and flush the output. The first instruction from the
// new target appears one advancing edge after the redirect edge.
//
// The memory is loaded through a byte-wide program port. It is not cleared by
// reset.
//
// Parameters
//   XLEN       width of pc / redirect address
//   MEM_BYTES  instruction memory size in bytes (power of two, >= 4)
//   RESET_PC   pc value loaded while reset is asserted
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   redirect_valid  branch/jump request this cycle
//   redirect_pc     redirect target address
//   out_ready       decode stage accepts the output this cycle
//   out_valid       out_pc/out_inst hold a valid fetched instruction
//   out_pc          address of the instruction in out_inst
//   out_inst        fetched instruction word
//   prog_we         program-load byte write enable
//   prog_addr       program-load byte address
//   prog_data       program-load byte data
//   fault           sticky misaligned-redirect flag
//
// Build option
//   FETCH_MISALIGN_CHECK_EN
//     When defined, a redirect to a non-word-aligned target sets a sticky
//     fault and halts fetch until reset.
//     When undefined, the two low target bits are dropped and fault is 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     MEM_BYTES = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [XLEN-1:0]              out_pc,
  output logic [31:0]                  out_inst,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
  input  logic [7:0]                   prog_data,
  output logic                         fault
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  typedef enum logic [0:0] {
    ST_FETCH,
    ST_HALT
  } state_t;

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  // Contents power up as zero and are deliberately left out of the reset
  // domain, so a reset keeps the loaded program.
  logic [7:0] r_mem [MEM_BYTES] = '{default: 8'h00};

  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [31:0]     r_out_inst;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_out_valid_nxt;
  logic [XLEN-1:0] w_out_pc_nxt;
  logic [31:0]     w_out_inst_nxt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            r_fault;
  logic            w_fault_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Combinational word read at pc
  // ---------------------------------------------------------------------------
  // Each byte index wraps independently at the top of memory. A word fetched
  // at MEM_BYTES-2 therefore takes its upper bytes from address 0 onward.
  logic [AW-1:0] w_idx0;
  logic [AW-1:0] w_idx1;
  logic [AW-1:0] w_idx2;
  logic [AW-1:0] w_idx3;
  logic [31:0]   w_word;
  logic          w_advance;

  assign w_idx0 = r_pc[AW-1:0];
  assign w_idx1 = w_idx0 + AW'(1);
  assign w_idx2 = w_idx0 + AW'(2);
  assign w_idx3 = w_idx0 + AW'(3);

  // The read happens before the edge. A program write on the same edge is
  // therefore not visible to that fetch.
  assign w_word = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};

  // The output register can take a new word when it is empty or being consumed.
  assign w_advance = !r_out_valid || out_ready;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_inst_nxt  = r_out_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_fault_nxt     = r_fault;
`endif

    case (r_state)
      ST_FETCH: begin
        if (redirect_valid) begin
          // A redirect outranks both advance and stall. The word currently
          // held at the output is dropped, so no stale instruction escapes.
          w_out_valid_nxt = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (redirect_pc[1:0] != 2'b00) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt = redirect_pc;
          end
`else
          w_pc_nxt = redirect_pc & ~XLEN'(3);
`endif
        end else if (w_advance) begin
          w_out_valid_nxt = 1'b1;
          w_out_pc_nxt    = r_pc;
          w_out_inst_nxt  = w_word;
          w_pc_nxt        = r_pc + XLEN'(4);
        end
      end

      ST_HALT: begin
        // Fetch stops and further redirects are ignored. Only reset leaves
        // this state.
        w_out_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt     = ST_FETCH;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_inst  <= w_out_inst_nxt;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_fault_nxt;
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit using 32-bit addresses and 64 bytes of
// memory. Expected transfers (pc, instruction) are queued when the stimulus
// makes them due. They are popped whenever the DUT hands a word to decode.
// State-specific behaviour such as stalls, bubbles and fault is checked
// directly.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_BYTES = 64;

  logic        clk            = 1'b0;
  logic        reset          = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        out_ready      = 1'b0;
  logic        prog_we        = 1'b0;
  logic [5:0]  prog_addr      = '0;
  logic [7:0]  prog_data      = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tb_mem [MEM_BYTES];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } xact_t;

  xact_t sb[$];

  fetch_unit #(
    .XLEN      (XLEN),
    .MEM_BYTES (MEM_BYTES),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Little-endian word with per-byte wrap at the top of memory.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    int unsigned b;
    b = a % MEM_BYTES;
    return {tb_mem[(b + 3) % MEM_BYTES], tb_mem[(b + 2) % MEM_BYTES],
            tb_mem[(b + 1) % MEM_BYTES], tb_mem[b]};
  endfunction

  task automatic push(input logic [31:0] a);
    xact_t x;
    x.pc   = a;
    x.inst = word_at(a);
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs only change at posedge+1. At the negedge, valid & ready & no
  // redirect therefore means the transfer will happen on the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !redirect_valid) begin
      xact_t x;
      check("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("acc_pc", out_pc, x.pc);
        check("acc_inst", out_inst, x.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] init8 [8];
    xact_t      x;

    init8 = '{8'h03, 8'h00, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00};

    // Load the program while reset is held; memory is outside reset.
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      tb_mem[i] = (i < 8) ? init8[i] : 8'($urandom);
      tick();
      prog_we   = 1'b1;
      prog_addr = 6'(i);
      prog_data = tb_mem[i];
    end
    tick();
    prog_we = 1'b0;

    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    // Streaming start, then stall at pc 4.
    x.pc = 32'h0; x.inst = 32'hFFC40003; sb.push_back(x);
    x.pc = 32'h4; x.inst = 32'h0064A423; sb.push_back(x);
    out_ready = 1'b1;
    reset     = 1'b0;
    tick();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'h0);
    tick();
    check("second_pc", out_pc, 32'h4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_pc", out_pc, 32'h4);
      check("stall_inst", out_inst, 32'h0064A423);
    end
    push(32'h8);
    out_ready = 1'b1;
    tick();
    check("resume_pc", out_pc, 32'h8);

    // Asynchronous reset in mid-cycle clears outputs without a clock edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_inst", out_inst, 32'd0);
    check("sb_drained_a", sb.size(), 32'd0);
    tick();

    // Redirect to 0x0C while pc 4 is at the output.
    push(32'h0);
    reset = 1'b0;
    tick();
    tick();
    check("pre_redir_pc", out_pc, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0C;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble", {31'd0, out_valid}, 32'd0);
    push(32'h0C);
    tick();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h0C);
    tick();
    check("redir_next", out_pc, 32'h10);
    out_ready = 1'b0;

    // Back-to-back redirects: 0x20 must never appear. Then 0x3C wraps.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    out_ready      = 1'b1;
    tick();
    redirect_pc = 32'h3C;
    tick();
    redirect_valid = 1'b0;
    check("b2b_bubble", {31'd0, out_valid}, 32'd0);
    push(32'h3C);
    x.pc = 32'h40; x.inst = 32'hFFC40003; sb.push_back(x);
    tick();
    check("wrap_pc_3c", out_pc, 32'h3C);
    tick();
    check("wrap_pc_40", out_pc, 32'h40);
    check("wrap_inst", out_inst, 32'hFFC40003);
    tick();
    out_ready = 1'b0;
    check("sb_drained_b", sb.size(), 32'd0);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h06;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check("mis_fault_sticky", {31'd0, fault}, 32'd1);
    check("mis_valid_held", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("mis_fault_clr", {31'd0, fault}, 32'd0);
    tick();
    push(32'h0);
    reset = 1'b0;
    tick();
    check("mis_restart_valid", {31'd0, out_valid}, 32'd1);
    check("mis_restart_pc", out_pc, 32'h0);
    out_ready = 1'b0;
`else
    redirect_valid = 1'b1;
    redirect_pc    = 32'h06;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("mis_bubble", {31'd0, out_valid}, 32'd0);
    push(32'h4);
    tick();
    check("mis_pc_aligned", out_pc, 32'h4);
    check("mis_no_fault", {31'd0, fault}, 32'd0);
    tick();
    out_ready = 1'b0;
    check("mis_no_fault_2", {31'd0, fault}, 32'd0);
`endif

    tick();
    check("sb_drained_end", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
